lsu_axi_gpio_wr_slave: RTL and testbench

AXI4 write-channel responder that terminates the BrqRV LSU AXI write master (AW, W and B channels) for a memory-mapped GPIO/LA output register pair.
- It accepts one single-beat write at a time and updates a 32-bit output-data register and a 32-bit output-enable register through byte strobes.
- It returns a proper B response with the captured ID.
- It sits in the user project between the core's lsu_axi_* write port and the io_out/io_oeb/la_data_out pads, replacing the tied-off handshakes.

---
 rtl/lsu_axi_gpio_wr_slave.sv | 107 ++++++++++
 tb/tb_lsu_axi_gpio_wr_slave.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_gpio_wr_slave.sv
// AXI4 write-channel responder for the LSU write port: single-beat writes into a
// GPIO output-data / output-enable register pair, with a proper B response.
module lsu_axi_gpio_wr_slave #(
    parameter int          ID_W      = 3,
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic            wvalid,
    output logic            wready,
    input  logic [63:0]     wdata,
    input  logic [7:0]      wstrb,
    input  logic            wlast,
    output logic            bvalid,
    input  logic            bready,
    output logic [1:0]      bresp,
    output logic [ID_W-1:0] bid,
    output logic [31:0]     gpio_out,
    output logic [31:0]     gpio_oe,
    output logic            wr_pulse
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [28:0]     addr_hi;  // awaddr[31:3]; the low bits never affect decode
        logic [7:0]      len;
    } aw_req_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_beat_t;

    logic    aw_held, w_held;
    aw_req_t aw_q;
    w_beat_t w_q;
    logic    commit, hit, ok;
    logic [31:0] out_nxt, oe_nxt;
    logic    unused_bits;

    assign unused_bits = ^{awsize, awaddr[2:0]};

    // Ready depends only on flops so the master never sees a valid->ready loop.
    assign awready = ~aw_held & ~bvalid;
    assign wready  = ~w_held  & ~bvalid;
    assign commit  = aw_held & w_held;

    assign hit = (aw_q.addr_hi[28:1] == BASE_ADDR[31:4]) && !aw_q.addr_hi[0];
    assign ok  = hit && (aw_q.len == 8'd0) && w_q.last;

    // Low 4 strobes steer the data register, upper 4 the output-enable register.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign out_nxt[8*i +: 8] = w_q.strb[i]   ? w_q.data[8*i +: 8]      : gpio_out[8*i +: 8];
        assign oe_nxt[8*i +: 8]  = w_q.strb[i+4] ? w_q.data[32+8*i +: 8]   : gpio_oe[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_q     <= '0;
            w_q      <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            bid      <= '0;
            gpio_out <= '0;
            gpio_oe  <= '0;
            wr_pulse <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            if (awvalid && awready) begin
                aw_held <= 1'b1;
                aw_q    <= '{id: awid, addr_hi: awaddr[31:3], len: awlen};
            end
            if (wvalid && wready) begin
                w_held <= 1'b1;
                w_q    <= '{data: wdata, strb: wstrb, last: wlast};
            end
            // Both holds set implies bvalid is low, so commit and B retire never collide.
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bid     <= aw_q.id;
                bresp   <= ok ? RESP_OKAY : RESP_SLVERR;
                if (ok) begin
                    gpio_out <= out_nxt;
                    gpio_oe  <= oe_nxt;
                    wr_pulse <= 1'b1;
                end
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_axi_gpio_wr_slave.sv
// Bench for lsu_axi_gpio_wr_slave: directed vector table, hand-written
// back-pressure / reset sequences, then random writes against a byte-merge model.
module tb_lsu_axi_gpio_wr_slave;

    localparam int          ID_W = 3;
    localparam logic [31:0] BASE = 32'hF000_0000;

    logic            clk = 1'b0;
    logic            rst_l;
    logic            awvalid, awready;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic            wvalid, wready;
    logic [63:0]     wdata;
    logic [7:0]      wstrb;
    logic            wlast;
    logic            bvalid, bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;
    logic [31:0]     gpio_out, gpio_oe;
    logic            wr_pulse;

    lsu_axi_gpio_wr_slave #(.ID_W(ID_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_l(rst_l),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int aw_hs_cyc, w_hs_cyc;
    logic [31:0] m_out, m_oe;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_pulse) pulse_cnt <= pulse_cnt + 1;
    end

    typedef struct {
        logic [2:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        int          aw_dly, w_dly, b_dly;
        logic [1:0]  e_resp;
        logic [31:0] e_out, e_oe;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out waiting on DUT (t=%0t)", name, $time);
    endtask

    // Reference rules, written from the register-map description.
    function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] en);
        logic [31:0] mask = 32'h0;
        for (int i = 0; i < 4; i++) if (en[i]) mask = mask | (32'hFF << (8 * i));
        return (old & ~mask) | (nw & mask);
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [7:0] len,
                                              input logic last);
        return ((addr >> 4) == (BASE >> 4) && (addr & 32'h8) == 0 && len == 0 && last)
               ? 2'b00 : 2'b10;
    endfunction

    task automatic send_aw(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input int dly, input bit w_first);
        int n;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("aw_wait_awready", awready, 1);
            if (w_first) chk("aw_wait_wready", wready, 0);
        end
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = 3'd3;
        n = 0;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("aw_handshake");
        aw_hs_cyc = cyc;
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last,
                          input int dly);
        int n;
        repeat (dly) @(negedge clk);
        wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
        n = 0;
        while (!wready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout("w_handshake");
        w_hs_cyc = cyc;
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic wait_b(input string name);
        int n = 0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout(name);
    endtask

    task automatic do_write(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [63:0] data, input logic [7:0] strb, input logic last,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] e_resp, input logic [31:0] e_out,
                            input logic [31:0] e_oe);
        int p0, later;
        p0 = pulse_cnt;
        fork
            send_aw(id, addr, len, aw_dly, (w_dly == 0 && aw_dly > 0));
            send_w(data, strb, last, w_dly);
        join
        wait_b("b_valid");
        later = (aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc;
        chk("b_latency", cyc, later + 2);
        chk("bid", bid, id);
        chk("bresp", bresp, e_resp);
        chk("wr_pulse_at_b", wr_pulse, e_resp == 2'b00);
        chk("gpio_out", gpio_out, e_out);
        chk("gpio_oe", gpio_oe, e_oe);
        for (int i = 0; i < b_dly; i++) begin
            bready = 1'b0;
            @(negedge clk);
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_bid", bid, id);
            chk("b_hold_bresp", bresp, e_resp);
            chk("b_hold_ready", {awready, wready}, 2'b00);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("b_cleared", bvalid, 0);
        chk("pulse_count", pulse_cnt - p0, (e_resp == 2'b00) ? 1 : 0);
        chk("ready_after_b", {awready, wready}, 2'b11);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        logic [2:0]  r_id;
        logic [31:0] r_addr;
        logic [7:0]  r_len, r_strb;
        logic [63:0] r_data;
        logic        r_last;
        logic [1:0]  r_resp;
        logic [31:0] e_out, e_oe;

        tbl[0] = '{3'd3, 32'hF000_0000, 8'd0, 64'h0000_00FF_1234_5678, 8'hFF, 1'b1, 0, 0, 0, 2'b00, 32'h1234_5678, 32'h0000_00FF};
        tbl[1] = '{3'd5, 32'hF000_0004, 8'd0, 64'h0000_0000_0000_00AB, 8'h01, 1'b1, 3, 0, 0, 2'b00, 32'h1234_56AB, 32'h0000_00FF};
        tbl[2] = '{3'd1, 32'hF000_0010, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 0, 1, 0, 2'b10, 32'h1234_56AB, 32'h0000_00FF};
        tbl[3] = '{3'd2, 32'hF000_0008, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 1, 0, 1, 2'b10, 32'h1234_56AB, 32'h0000_00FF};
        tbl[4] = '{3'd7, 32'hF000_0000, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 0, 0, 0, 2'b10, 32'h1234_56AB, 32'h0000_00FF};
        tbl[5] = '{3'd0, 32'hF000_0000, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 0, 0, 2, 2'b10, 32'h1234_56AB, 32'h0000_00FF};
        tbl[6] = '{3'd6, 32'hF000_0004, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, 0, 0, 0, 2'b00, 32'h1234_56AB, 32'h0000_00FF};
        tbl[7] = '{3'd4, 32'hF000_0000, 8'd0, 64'hA5A5_0F0F_0000_0000, 8'hF0, 1'b1, 0, 0, 5, 2'b00, 32'h1234_56AB, 32'hA5A5_0F0F};
        tbl[8] = '{3'd3, 32'hF000_0000, 8'd0, 64'h0000_0000_CAFE_0000, 8'h0C, 1'b1, 0, 2, 0, 2'b00, 32'hCAFE_56AB, 32'hA5A5_0F0F};
        tbl[9] = '{3'd1, 32'hF000_000C, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 0, 0, 0, 2'b10, 32'hCAFE_56AB, 32'hA5A5_0F0F};

        rst_l = 1'b1;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        #2 rst_l = 1'b0;
        #1;
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_bid", bid, 0);
        chk("rst_gpio_out", gpio_out, 0);
        chk("rst_gpio_oe", gpio_oe, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++)
            do_write(tbl[v].id, tbl[v].addr, tbl[v].len, tbl[v].data, tbl[v].strb, tbl[v].last,
                     tbl[v].aw_dly, tbl[v].w_dly, tbl[v].b_dly,
                     tbl[v].e_resp, tbl[v].e_out, tbl[v].e_oe);
        m_out = tbl[9].e_out;
        m_oe  = tbl[9].e_oe;

        // New AW presented while a response is stalled: must wait for the B handshake.
        fork
            send_aw(3'd1, BASE, 8'd0, 0, 1'b0);
            send_w(64'h0000_0077_0000_0066, 8'h11, 1'b1, 0);
        join
        wait_b("ovl_b1");
        chk("ovl_bid1", bid, 1);
        m_out = merge32(m_out, 32'h66, 4'h1);
        m_oe  = merge32(m_oe, 32'h77, 4'h1);
        awvalid = 1'b1; awid = 3'd2; awaddr = BASE + 32'h4; awlen = 8'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ovl_awready_blocked", awready, 0);
            chk("ovl_bvalid_held", bvalid, 1);
            chk("ovl_bid_held", bid, 1);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("ovl_bvalid_clear", bvalid, 0);
        chk("ovl_awready_open", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
        chk("ovl_aw_taken", {awready, wready}, 2'b01);
        send_w(64'h0000_0000_0000_9900, 8'h02, 1'b1, 0);
        wait_b("ovl_b2");
        m_out = merge32(m_out, 32'h9900, 4'h2);
        chk("ovl_bid2", bid, 2);
        chk("ovl_bresp2", bresp, 0);
        chk("ovl_gpio_out", gpio_out, m_out);
        chk("ovl_gpio_oe", gpio_oe, m_oe);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;

        // Reset with AW held and W pending: the transaction is dropped silently.
        send_aw(3'd6, BASE, 8'd0, 0, 1'b0);
        wvalid = 1'b1; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wstrb = 8'hFF; wlast = 1'b1;
        #1 rst_l = 1'b0;
        #1;
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_bid", bid, 0);
        chk("mid_rst_gpio_out", gpio_out, 0);
        chk("mid_rst_gpio_oe", gpio_oe, 0);
        chk("mid_rst_ready", {awready, wready}, 2'b11);
        m_out = 32'h0;
        m_oe  = 32'h0;
        @(negedge clk);
        wvalid = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_b", bvalid, 0);
        end
        chk("post_rst_gpio_out", gpio_out, 0);
        m_out = merge32(m_out, 32'hDEAD_BEEF, 4'hF);
        do_write(3'd4, BASE + 32'h4, 8'd0, 64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b1, 0, 0, 0,
                 2'b00, m_out, m_oe);

        // Random writes against the byte-merge model.
        for (int k = 0; k < 10; k++) begin
            r_id   = 3'($urandom_range(0, 7));
            r_addr = BASE | ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 4) == 0) r_addr = $urandom();
            r_len  = ($urandom_range(0, 5) == 0) ? 8'd1 : 8'd0;
            r_last = ($urandom_range(0, 5) != 0);
            r_data = {$urandom(), $urandom()};
            r_strb = 8'($urandom_range(0, 255));
            r_resp = model_resp(r_addr, r_len, r_last);
            e_out  = m_out;
            e_oe   = m_oe;
            if (r_resp == 2'b00) begin
                e_out = merge32(m_out, r_data[31:0], r_strb[3:0]);
                e_oe  = merge32(m_oe, r_data[63:32], r_strb[7:4]);
            end
            do_write(r_id, r_addr, r_len, r_data, r_strb, r_last,
                     $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                     r_resp, e_out, e_oe);
            m_out = e_out;
            m_oe  = e_oe;
        end
        chk("final_gpio_out", gpio_out, m_out);
        chk("final_gpio_oe", gpio_oe, m_oe);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
